// File: rtl/tap_ctrl_if.sv
// rtl/tap_ctrl_if.sv - TAP serial pins plus boundary/scan chain strobes for tap_ctrl
// Ports (master = test host and chain side, slave = tap_ctrl):
//   tms, tdi         host -> controller
//   bsr_so, scan_so  chain tails -> controller
//   tdo, tdo_en      controller -> host
//   shift, clk_dr, update, sel, scan_en  controller -> boundary/scan cells
interface tap_ctrl_if;
    logic tms;
    logic tdi;
    logic bsr_so;
    logic scan_so;
    logic tdo;
    logic tdo_en;
    logic shift;
    logic clk_dr;
    logic update;
    logic sel;
    logic scan_en;

    modport master (
        output tms, tdi, bsr_so, scan_so,
        input  tdo, tdo_en, shift, clk_dr, update, sel, scan_en
    );

    modport slave (
        input  tms, tdi, bsr_so, scan_so,
        output tdo, tdo_en, shift, clk_dr, update, sel, scan_en
    );
endinterface

// File: rtl/tap_ctrl.sv
// rtl/tap_ctrl.sv - JTAG TAP controller: 16-state FSM, IR, bypass/IDCODE, chain strobes
// Ports:
//   clock  single test/system clock, rising edge
//   rst_l  synchronous active-low reset
//   tap    tap_ctrl_if.slave: tms/tdi/bsr_so/scan_so in; tdo/tdo_en and
//          shift/clk_dr/update/sel/scan_en out
module tap_ctrl #(
    parameter int              IR_W   = 3,
    parameter int              ID_W   = 32,
    parameter logic [ID_W-1:0] ID_VAL = 32'h1000_0001
) (
    input  logic       clock,
    input  logic       rst_l,
    tap_ctrl_if.slave  tap
);

    localparam logic [3:0] TLR    = 4'd0;
    localparam logic [3:0] RTI    = 4'd1;
    localparam logic [3:0] SEL_DR = 4'd2;
    localparam logic [3:0] CAP_DR = 4'd3;
    localparam logic [3:0] SHF_DR = 4'd4;
    localparam logic [3:0] EX1_DR = 4'd5;
    localparam logic [3:0] PAU_DR = 4'd6;
    localparam logic [3:0] EX2_DR = 4'd7;
    localparam logic [3:0] UPD_DR = 4'd8;
    localparam logic [3:0] SEL_IR = 4'd9;
    localparam logic [3:0] CAP_IR = 4'd10;
    localparam logic [3:0] SHF_IR = 4'd11;
    localparam logic [3:0] EX1_IR = 4'd12;
    localparam logic [3:0] PAU_IR = 4'd13;
    localparam logic [3:0] EX2_IR = 4'd14;
    localparam logic [3:0] UPD_IR = 4'd15;

    localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(0);
    localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(1);
    localparam logic [IR_W-1:0] OP_SCAN   = IR_W'(2);
    localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(3);

    logic [3:0]      state;
    logic [3:0]      state_nxt;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_sr;
    logic            bypass;
    logic [ID_W-1:0] id_sr;

    logic is_extest;
    logic is_scan;
    logic is_idcode;
    logic bsr_sel;
    logic is_bypass;

    assign is_extest = (ir == OP_EXTEST);
    assign is_scan   = (ir == OP_SCAN);
    assign is_idcode = (ir == OP_IDCODE);
    assign bsr_sel   = is_extest | (ir == OP_SAMPLE);
    // Every opcode without its own data register falls through to bypass.
    assign is_bypass = !(bsr_sel | is_scan | is_idcode);

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:    state_nxt = tap.tms ? TLR    : RTI;
            RTI:    state_nxt = tap.tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tap.tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tap.tms ? EX1_DR : SHF_DR;
            SHF_DR: state_nxt = tap.tms ? EX1_DR : SHF_DR;
            EX1_DR: state_nxt = tap.tms ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = tap.tms ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = tap.tms ? UPD_DR : SHF_DR;
            UPD_DR: state_nxt = tap.tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = tap.tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tap.tms ? EX1_IR : SHF_IR;
            SHF_IR: state_nxt = tap.tms ? EX1_IR : SHF_IR;
            EX1_IR: state_nxt = tap.tms ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = tap.tms ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = tap.tms ? UPD_IR : SHF_IR;
            UPD_IR: state_nxt = tap.tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_l) begin
            state  <= TLR;
            ir     <= OP_IDCODE;
            ir_sr  <= '0;
            bypass <= 1'b0;
            id_sr  <= '0;
        end else begin
            state <= state_nxt;

            case (state)
                CAP_IR: ir_sr <= IR_W'(1);
                SHF_IR: ir_sr <= {tap.tdi, ir_sr[IR_W-1:1]};
                default: ;
            endcase

            if (state == CAP_DR) begin
                if (is_bypass) bypass <= 1'b0;
                if (is_idcode) id_sr  <= ID_VAL;
            end else if (state == SHF_DR) begin
                if (is_bypass) bypass <= tap.tdi;
                if (is_idcode) id_sr  <= {tap.tdi, id_sr[ID_W-1:1]};
            end

            // TLR entry wins over UPD_IR; the two cannot coincide anyway
            // since UPD_IR never leads to TLR.
            if (state_nxt == TLR)
                ir <= OP_IDCODE;
            else if (state == UPD_IR)
                ir <= ir_sr;
        end
    end

    always_comb begin
        tap.tdo = 1'b0;
        if (state == SHF_IR) begin
            tap.tdo = ir_sr[0];
        end else if (state == SHF_DR) begin
            if (bsr_sel)        tap.tdo = tap.bsr_so;
            else if (is_scan)   tap.tdo = tap.scan_so;
            else if (is_idcode) tap.tdo = id_sr[0];
            else                tap.tdo = bypass;
        end
    end

    assign tap.tdo_en  = (state == SHF_DR) || (state == SHF_IR);
    assign tap.shift   = (state == SHF_DR) && bsr_sel;
    assign tap.clk_dr  = ((state == CAP_DR) || (state == SHF_DR)) && bsr_sel;
    assign tap.update  = (state == UPD_DR) && bsr_sel;
    assign tap.scan_en = (state == SHF_DR) && is_scan;
    assign tap.sel     = is_extest && (state != TLR);

endmodule
